// File: rtl/inst_cache.sv
// ---------------------------------------------------------------------------
// inst_cache -- direct-mapped instruction cache with 128-bit lines.
//
// A fetch is accepted in IDLE (or in LOOKUP right after a hit) and looked up
// one cycle later.
// - Hit: the line is presented combinationally in the LOOKUP cycle.
//   Back-to-back hits therefore stream one line per cycle.
// - Miss: the line is requested from backing memory. Once mem_ack arrives it
//   is written into the array and presented in the RESP cycle.
//
// Optional feature (macro ICACHE_STATS_EN): saturating 16-bit hit/miss
// counters exported on hit_count / miss_count.
//
// Parameters
//   NUM_LINES   number of lines (power of 2, 2..256)
//
// Ports
//   clk          clock, rising edge
//   rst          asynchronous active-low reset
//   pc_in        byte fetch address (offset [3:0], index, tag)
//   cache_rd_en  fetch request, held by the requester until accepted
//   cache_abort  cancels any in-flight fetch response
//   dout         fetched line, word k at [32k+31:32k]; holds when not valid
//   dout_valid   one-cycle strobe qualifying dout
//   mem_req      line-fill request to backing memory
//   mem_addr     line-aligned fill address
//   mem_ack      fill-complete strobe, mem_data valid in the same cycle
//   mem_data     fill line
//   hit_count    (ICACHE_STATS_EN) lookup hits, saturating
//   miss_count   (ICACHE_STATS_EN) lookup misses, saturating
// ---------------------------------------------------------------------------
module inst_cache #(
    parameter int NUM_LINES = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  pc_in,
    input  logic         cache_rd_en,
    input  logic         cache_abort,
    output logic [127:0] dout,
    output logic         dout_valid,
    output logic         mem_req,
    output logic [31:0]  mem_addr,
    input  logic         mem_ack,
    input  logic [127:0] mem_data
`ifdef ICACHE_STATS_EN
    ,
    output logic [15:0]  hit_count,
    output logic [15:0]  miss_count
`endif
);

    localparam int IW = $clog2(NUM_LINES);
    localparam int TW = 28 - IW;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        MISS   = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t state, state_nxt;

    // Only the line address is kept. The whole line is returned, so the
    // byte offset is never needed.
    logic [27:0]          req_line;
    logic                 unused_offset;
    logic [IW-1:0]        req_idx;
    logic [TW-1:0]        req_tag;

    logic [127:0]         line_mem [NUM_LINES];
    logic [TW-1:0]        tag_mem  [NUM_LINES];
    logic [NUM_LINES-1:0] valid_q;

    logic [127:0]         dout_q;
    logic                 abort_pend_q, abort_pend_nxt;

    logic                 hit;
    logic                 accept;
    logic                 fill_we;
    logic                 lookup_hit;
    logic                 lookup_miss;

    assign unused_offset = ^pc_in[3:0];
    assign req_idx       = req_line[IW-1:0];
    assign req_tag       = req_line[27:IW];
    assign hit           = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);

    // ------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt      = state;
        abort_pend_nxt = abort_pend_q;
        accept         = 1'b0;
        fill_we        = 1'b0;
        dout_valid     = 1'b0;
        mem_req        = 1'b0;
        lookup_hit     = 1'b0;
        lookup_miss    = 1'b0;

        case (state)
            IDLE: begin
                if (cache_rd_en && !cache_abort) begin
                    accept    = 1'b1;
                    state_nxt = LOOKUP;
                end
            end

            LOOKUP: begin
                if (cache_abort) begin
                    state_nxt = IDLE;
                end else if (hit) begin
                    lookup_hit = 1'b1;
                    dout_valid = 1'b1;
                    if (cache_rd_en) begin
                        accept    = 1'b1;
                        state_nxt = LOOKUP;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    lookup_miss    = 1'b1;
                    abort_pend_nxt = 1'b0;
                    state_nxt      = MISS;
                end
            end

            MISS: begin
                // The fill always runs to completion. An abort only
                // remembers that the response must not be presented.
                mem_req = 1'b1;
                if (cache_abort) begin
                    abort_pend_nxt = 1'b1;
                end
                if (mem_ack) begin
                    fill_we   = 1'b1;
                    state_nxt = (abort_pend_q || cache_abort) ? IDLE : RESP;
                end
            end

            RESP: begin
                dout_valid = !cache_abort;
                state_nxt  = IDLE;
            end

            default: state_nxt = IDLE;
        endcase
    end

    assign mem_addr = mem_req ? {req_line, 4'h0} : 32'h0;

    // In both LOOKUP-hit and RESP, the array entry at req_idx holds the line
    // being returned (in RESP it was written at the mem_ack edge). Otherwise
    // the last delivered line is replayed from dout_q.
    assign dout = dout_valid ? line_mem[req_idx] : dout_q;

    // ------------------------------------------------------------------
    // Control state (asynchronously reset)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            abort_pend_q <= 1'b0;
            valid_q      <= '0;
            dout_q       <= '0;
        end else begin
            state        <= state_nxt;
            abort_pend_q <= abort_pend_nxt;
            if (fill_we) begin
                valid_q[req_idx] <= 1'b1;
            end
            if (dout_valid) begin
                dout_q <= dout;
            end
        end
    end

    // ------------------------------------------------------------------
    // Request address and line storage (no reset needed)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (accept) begin
            req_line <= pc_in[31:4];
        end
    end

    always_ff @(posedge clk) begin
        if (fill_we) begin
            line_mem[req_idx] <= mem_data;
            tag_mem[req_idx]  <= req_tag;
        end
    end

`ifdef ICACHE_STATS_EN
    // ------------------------------------------------------------------
    // Lookup statistics; aborted lookups are not counted
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_count  <= 16'h0;
            miss_count <= 16'h0;
        end else begin
            if (lookup_hit && (hit_count != 16'hFFFF)) begin
                hit_count <= hit_count + 16'h1;
            end
            if (lookup_miss && (miss_count != 16'hFFFF)) begin
                miss_count <= miss_count + 16'h1;
            end
        end
    end
`else
    logic unused_stats;
    assign unused_stats = lookup_hit ^ lookup_miss;
`endif

endmodule
